present_bus_master: RTL and testbench
=====================================

Name: present_bus_master

Overview:
- Bus initiator that runs one complete PRESENT-80 block operation through the memory-mapped PRESENT slave port.
- Accepts a command (key, 64-bit block, mode) on a valid/ready interface.
- Issues the register write sequence, waits a fixed core latency, reads back the 64-bit result and returns it on a valid/ready response interface.
- Sits between a DMA or test sequencer and the PRESENT peripheral, driving its chipselect/write/read/address/data pins directly.

Parameters:
- WAIT_CYCLES, 40, cycles spent in WAIT between load-clear and first read. Legal range 1..255. Must cover the core's 32-round latency plus margin.

Ports:
- clk  in  1  clock
- iReset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  high only in IDLE
- cmd_key  in  80  PRESENT key
- cmd_data  in  64  input block
- cmd_mode  in  1  value written verbatim to control register (addr 8)
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result accepted
- rsp_data  out  64  result block
- oChipselect_n  out  1  bus chip select, active low
- oWrite_n  out  1  bus write strobe, active low
- oRead_n  out  1  bus read strobe, active low
- oAddress  out  4  bus word address
- odat  out  32  bus write data
- idat  in  32  bus read data; registered by slave, valid one cycle after read strobe
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: see below.
- All bus outputs and rsp_* are registered, with no combinational path from any input to any output.
- Reset values:
  - oChipselect_n=1, oWrite_n=1, oRead_n=1, oAddress=0, odat=0
  - rsp_valid=0, rsp_data=0, busy=0, cmd_ready=1, state=IDLE
- Reset is asynchronous and aborts any operation immediately in any state. No partial response is produced.
- IDLE:
  - Accept when cmd_valid&&cmd_ready (cycle T).
  - Latch cmd_key, cmd_data and cmd_mode into internal registers; inputs may change afterwards.
  - cmd_valid while not IDLE is ignored (not queued).
- WR: seven consecutive single-cycle writes at T+1..T+7, each with CS_n=0, Write_n=0, Read_n=1:
  - addr 3 = key[79:48]
  - addr 2 = key[47:16]
  - addr 1 = {16'h0, key[15:0]}
  - addr 5 = data[63:32]
  - addr 4 = data[31:0]
  - addr 8 = {31'h0, mode}
  - addr 0 = 32'h1 (load)
- CLR, T+8: CS_n=0, Write_n=1, Read_n=1, addr 0. This non-write selected cycle deasserts the slave's load.
- WAIT:
  - Runs T+9..T+8+W (W=WAIT_CYCLES).
  - CS_n=1, all strobes high.
  - An 8-bit down-counter is loaded with W on CLR exit; WAIT exits when it reaches 1.
- RD_HI, T+9+W: CS_n=0, Read_n=0, addr 7.
- CAP_HI, T+10+W: strobes deasserted (CS_n=1); capture idat into result[63:32].
- RD_LO, T+11+W: CS_n=0, Read_n=0, addr 6.
- CAP_LO, T+12+W: strobes deasserted; capture idat into result[31:0].
- RESP:
  - rsp_valid=1 from T+13+W, with rsp_data=result.
  - Held stable until rsp_ready is sampled high; that cycle clears rsp_valid and returns to IDLE.
  - cmd_ready is high the following cycle, so minimum command spacing is 14+W cycles.
- rsp_data holds its last value after handshake until the next CAP_HI.
- odat is returned to 0 whenever Write_n=1.
- oAddress holds its last value while CS_n=1.
- At no cycle are Write_n and Read_n low together.

Test Plan:
1. Golden slave model, key=0, data=0, mode=0, W=40 → rsp_data=64'h5579C1387B228445, rsp_valid first high at accept+53.
2. key=80'hFFFF_FFFFFFFF_FFFFFFFF, data=0, mode=0 → rsp_data=64'hE72C46C0F5945049. Bus trace shows addresses 3,2,1,5,4,8,0 with write data FFFFFFFF, FFFFFFFF, 0000FFFF, 0, 0, 0, 1, then a CLR cycle with CS_n=0 and both strobes high.
3. Round trip: feed scenario 1's result back with mode=1, key=0 → rsp_data=0; control write data=32'h1.
4. Backpressure: rsp_ready held low 10 cycles → rsp_valid and rsp_data stable all 10 cycles, cmd_ready=0 throughout. Extra cmd_valid pulses during busy produce no bus activity.
5. Reset mid-WAIT (iReset_n low at accept+20) → same cycle all strobes high, CS_n=1, busy=0, rsp_valid=0. A new command after release completes correctly.
6. W=1 → rsp_valid at accept+14, result still correct against the model.

Source files
------------

// File: rtl/present_bus_master_if.sv
// ---------------------------------------------------------------------------
// present_bus_master_if
//   Bundles the command and response handshakes and the PRESENT peripheral
//   bus pins used by present_bus_master.
//
//   Command  : cmd_valid, cmd_ready, cmd_key[79:0], cmd_data[63:0], cmd_mode
//   Response : rsp_valid, rsp_ready, rsp_data[63:0]
//   Bus      : oChipselect_n, oWrite_n, oRead_n, oAddress[3:0], odat[31:0],
//              idat[31:0]
//   Status   : busy
//
//   Modport "master" is the bus-initiator side (present_bus_master).
//   Modport "slave" is everything around it: the command source, the
//   response sink and the PRESENT peripheral.
// ---------------------------------------------------------------------------
interface present_bus_master_if;

   logic          cmd_valid;
   logic          cmd_ready;
   logic [79:0]   cmd_key;
   logic [63:0]   cmd_data;
   logic          cmd_mode;

   logic          rsp_valid;
   logic          rsp_ready;
   logic [63:0]   rsp_data;

   logic          oChipselect_n;
   logic          oWrite_n;
   logic          oRead_n;
   logic [3:0]    oAddress;
   logic [31:0]   odat;
   logic [31:0]   idat;

   logic          busy;

   modport master (
      input  cmd_valid, cmd_key, cmd_data, cmd_mode,
      input  rsp_ready,
      input  idat,
      output cmd_ready,
      output rsp_valid, rsp_data,
      output oChipselect_n, oWrite_n, oRead_n, oAddress, odat,
      output busy
   );

   modport slave (
      output cmd_valid, cmd_key, cmd_data, cmd_mode,
      output rsp_ready,
      output idat,
      input  cmd_ready,
      input  rsp_valid, rsp_data,
      input  oChipselect_n, oWrite_n, oRead_n, oAddress, odat,
      input  busy
   );

endinterface

// File: rtl/present_bus_master.sv
// ---------------------------------------------------------------------------
// present_bus_master
//   Runs one complete PRESENT-80 block operation through the memory-mapped
//   PRESENT slave port: accepts a command, writes key/data/mode and the load
//   bit, waits a fixed core latency, reads the 64-bit result back in two
//   words and returns it on a valid/ready response.
//
//   Parameters
//     WAIT_CYCLES : cycles spent idle on the bus between the load-clear
//                   cycle and the first read (1..255). Must cover the core's
//                   32-round latency plus margin.
//
//   Ports
//     clk      : clock
//     iReset_n : asynchronous active-low reset, aborts any operation
//     bus      : present_bus_master_if.master
//                  cmd_*  command handshake (cmd_ready high only in IDLE)
//                  rsp_*  response handshake (rsp_data = result block)
//                  o*/idat PRESENT peripheral bus; idat is registered by the
//                         slave and valid one cycle after the read strobe
//                  busy   high in every state except IDLE
//
//   Every output is a flop; nothing from an input reaches an output
//   combinationally.
// ---------------------------------------------------------------------------
module present_bus_master #(
   parameter int unsigned WAIT_CYCLES = 40
) (
   input  logic                  clk,
   input  logic                  iReset_n,
   present_bus_master_if.master  bus
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_WR,
      S_CLR,
      S_WAIT,
      S_RD_HI,
      S_CAP_HI,
      S_RD_LO,
      S_CAP_LO,
      S_RESP
   } state_t;

   localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYCLES);

   // Slave register map
   localparam logic [3:0] A_LOAD   = 4'd0;
   localparam logic [3:0] A_KEY_LO = 4'd1;
   localparam logic [3:0] A_KEY_MD = 4'd2;
   localparam logic [3:0] A_KEY_HI = 4'd3;
   localparam logic [3:0] A_DAT_LO = 4'd4;
   localparam logic [3:0] A_DAT_HI = 4'd5;
   localparam logic [3:0] A_RES_LO = 4'd6;
   localparam logic [3:0] A_RES_HI = 4'd7;
   localparam logic [3:0] A_CTRL   = 4'd8;

   state_t        state;
   logic [2:0]    wr_idx;
   logic [7:0]    wait_cnt;

   logic [79:0]   key_q;
   logic [63:0]   data_q;
   logic          mode_q;

   logic          accept;

   // Address and write data of write beat idx (0..6). The load write is
   // last so the slave sees a fully programmed key/data/control set.
   function automatic logic [35:0] wr_beat(
      input logic [2:0]  idx,
      input logic [79:0] key,
      input logic [63:0] data,
      input logic        mode
   );
      logic [35:0] beat;
      case (idx)
         3'd0:    beat = {A_KEY_HI, key[79:48]};
         3'd1:    beat = {A_KEY_MD, key[47:16]};
         3'd2:    beat = {A_KEY_LO, 16'h0, key[15:0]};
         3'd3:    beat = {A_DAT_HI, data[63:32]};
         3'd4:    beat = {A_DAT_LO, data[31:0]};
         3'd5:    beat = {A_CTRL, 31'h0, mode};
         default: beat = {A_LOAD, 32'h1};
      endcase
      return beat;
   endfunction

   assign accept = (state == S_IDLE) && bus.cmd_valid && bus.cmd_ready;

   // Command capture: the source may change its inputs right after the
   // handshake, so the whole command is held here for the write sequence.
   always_ff @(posedge clk) begin
      if (accept) begin
         key_q  <= bus.cmd_key;
         data_q <= bus.cmd_data;
         mode_q <= bus.cmd_mode;
      end
   end

   // Sequencer. Bus and response outputs are registered here and always
   // describe the cycle that follows the edge, i.e. the next state's pins.
   always_ff @(posedge clk or negedge iReset_n) begin
      if (!iReset_n) begin
         state             <= S_IDLE;
         wr_idx            <= 3'd0;
         wait_cnt          <= 8'd0;
         bus.oChipselect_n <= 1'b1;
         bus.oWrite_n      <= 1'b1;
         bus.oRead_n       <= 1'b1;
         bus.oAddress      <= 4'd0;
         bus.odat          <= 32'd0;
         bus.rsp_valid     <= 1'b0;
         bus.rsp_data      <= 64'd0;
         bus.busy          <= 1'b0;
         bus.cmd_ready     <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  // First beat comes straight from the command inputs since
                  // key_q/data_q/mode_q load on this same edge.
                  {bus.oAddress, bus.odat} <= wr_beat(3'd0, bus.cmd_key,
                                                      bus.cmd_data, bus.cmd_mode);
                  bus.oChipselect_n <= 1'b0;
                  bus.oWrite_n      <= 1'b0;
                  bus.oRead_n       <= 1'b1;
                  bus.cmd_ready     <= 1'b0;
                  bus.busy          <= 1'b1;
                  wr_idx            <= 3'd1;
                  state             <= S_WR;
               end
            end

            S_WR: begin
               if (wr_idx == 3'd7) begin
                  // Selected but non-write cycle: drops the slave's load bit.
                  bus.oWrite_n <= 1'b1;
                  bus.oAddress <= A_LOAD;
                  bus.odat     <= 32'd0;
                  state        <= S_CLR;
               end else begin
                  {bus.oAddress, bus.odat} <= wr_beat(wr_idx, key_q, data_q, mode_q);
                  wr_idx <= wr_idx + 3'd1;
               end
            end

            S_CLR: begin
               bus.oChipselect_n <= 1'b1;
               wait_cnt          <= WAIT_INIT;
               state             <= S_WAIT;
            end

            S_WAIT: begin
               // Loaded with W on entry and left at 1, giving exactly W
               // cycles in this state.
               if (wait_cnt == 8'd1) begin
                  bus.oChipselect_n <= 1'b0;
                  bus.oRead_n       <= 1'b0;
                  bus.oAddress      <= A_RES_HI;
                  state             <= S_RD_HI;
               end else begin
                  wait_cnt <= wait_cnt - 8'd1;
               end
            end

            S_RD_HI: begin
               bus.oChipselect_n <= 1'b1;
               bus.oRead_n       <= 1'b1;
               state             <= S_CAP_HI;
            end

            S_CAP_HI: begin
               // Slave registered the high word at the end of the read cycle.
               bus.rsp_data[63:32] <= bus.idat;
               bus.oChipselect_n   <= 1'b0;
               bus.oRead_n         <= 1'b0;
               bus.oAddress        <= A_RES_LO;
               state               <= S_RD_LO;
            end

            S_RD_LO: begin
               bus.oChipselect_n <= 1'b1;
               bus.oRead_n       <= 1'b1;
               state             <= S_CAP_LO;
            end

            S_CAP_LO: begin
               bus.rsp_data[31:0] <= bus.idat;
               bus.rsp_valid      <= 1'b1;
               state              <= S_RESP;
            end

            S_RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  bus.busy      <= 1'b0;
                  bus.cmd_ready <= 1'b1;
                  state         <= S_IDLE;
               end
            end

            default: begin
               bus.oChipselect_n <= 1'b1;
               bus.oWrite_n      <= 1'b1;
               bus.oRead_n       <= 1'b1;
               bus.odat          <= 32'd0;
               bus.rsp_valid     <= 1'b0;
               bus.busy          <= 1'b0;
               bus.cmd_ready     <= 1'b1;
               state             <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_present_bus_master.sv
// ---------------------------------------------------------------------------
// tb_present_bus_master
//   Bench for present_bus_master. Two instances (WAIT_CYCLES 40 and 1) each
//   talk to a behavioural PRESENT slave whose result is computed by a
//   reference PRESENT-80 model. Expected responses go into a queue when a
//   command is issued and are popped when the response handshake happens.
// ---------------------------------------------------------------------------
module tb_present_bus_master;

   logic clk = 1'b0;
   logic iReset_n;
   always #5 clk = ~clk;

   present_bus_master_if ifa ();
   present_bus_master_if ifb ();

   present_bus_master #(.WAIT_CYCLES(40)) dut (
      .clk      (clk),
      .iReset_n (iReset_n),
      .bus      (ifa.master)
   );

   present_bus_master #(.WAIT_CYCLES(1)) dut_w1 (
      .clk      (clk),
      .iReset_n (iReset_n),
      .bus      (ifb.master)
   );

   int checks = 0;
   int errors = 0;

   // Stimulus is steered to one instance at a time.
   logic        sel = 1'b0;
   logic        cmd_valid_d = 1'b0;
   logic [79:0] cmd_key_d = '0;
   logic [63:0] cmd_data_d = '0;
   logic        cmd_mode_d = 1'b0;
   logic        rsp_ready_d = 1'b0;

   assign ifa.cmd_valid = cmd_valid_d & ~sel;
   assign ifb.cmd_valid = cmd_valid_d & sel;
   assign ifa.rsp_ready = rsp_ready_d & ~sel;
   assign ifb.rsp_ready = rsp_ready_d & sel;
   assign ifa.cmd_key   = cmd_key_d;
   assign ifb.cmd_key   = cmd_key_d;
   assign ifa.cmd_data  = cmd_data_d;
   assign ifb.cmd_data  = cmd_data_d;
   assign ifa.cmd_mode  = cmd_mode_d;
   assign ifb.cmd_mode  = cmd_mode_d;

   wire        rsp_valid_m = sel ? ifb.rsp_valid : ifa.rsp_valid;
   wire [63:0] rsp_data_m  = sel ? ifb.rsp_data  : ifa.rsp_data;
   wire        cmd_ready_m = sel ? ifb.cmd_ready : ifa.cmd_ready;
   wire        busy_m      = sel ? ifb.busy      : ifa.busy;

   // ---------------- PRESENT-80 reference model ----------------
   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [3:0] t [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                             4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
      return t[x];
   endfunction

   function automatic logic [3:0] sbox_inv(input logic [3:0] y);
      logic [3:0] r = 4'h0;
      for (int v = 0; v < 16; v++)
         if (sbox(4'(v)) == y) r = 4'(v);
      return r;
   endfunction

   function automatic int pbit(input int i);
      return (i == 63) ? 63 : (i * 16) % 63;
   endfunction

   function automatic logic [63:0] s_layer(input logic [63:0] s, input bit inv);
      logic [63:0] r;
      for (int n = 0; n < 16; n++)
         r[n*4 +: 4] = inv ? sbox_inv(s[n*4 +: 4]) : sbox(s[n*4 +: 4]);
      return r;
   endfunction

   function automatic logic [63:0] p_layer(input logic [63:0] s, input bit inv);
      logic [63:0] r;
      for (int i = 0; i < 64; i++)
         if (inv) r[i] = s[pbit(i)];
         else     r[pbit(i)] = s[i];
      return r;
   endfunction

   function automatic logic [79:0] key_next(input logic [79:0] k, input int rnd);
      logic [79:0] n;
      n = {k[18:0], k[79:19]};
      n[79:76] = sbox(n[79:76]);
      n[19:15] = n[19:15] ^ 5'(rnd);
      return n;
   endfunction

   function automatic logic [63:0] present_enc(input logic [63:0] pt, input logic [79:0] key);
      logic [63:0] s = pt;
      logic [79:0] k = key;
      for (int r = 1; r <= 31; r++) begin
         s = s ^ k[79:16];
         s = p_layer(s_layer(s, 1'b0), 1'b0);
         k = key_next(k, r);
      end
      return s ^ k[79:16];
   endfunction

   function automatic logic [63:0] present_dec(input logic [63:0] ct, input logic [79:0] key);
      logic [63:0] rk [33];
      logic [63:0] s;
      logic [79:0] k = key;
      for (int r = 1; r <= 32; r++) begin
         rk[r] = k[79:16];
         if (r < 32) k = key_next(k, r);
      end
      s = ct ^ rk[32];
      for (int r = 31; r >= 1; r--)
         s = s_layer(p_layer(s, 1'b1), 1'b1) ^ rk[r];
      return s;
   endfunction

   // ---------------- behavioural PRESENT slaves ----------------
   // kind: 0 write, 1 selected idle (load clear), 2 read
   typedef struct packed {
      logic [1:0]  kind;
      logic [3:0]  addr;
      logic [31:0] data;
   } ev_t;
   ev_t loga[$];

   logic [79:0] ka, kb;
   logic [63:0] da, db, ra, rb;
   logic        ma, mb;

   always @(posedge clk) begin
      if (ifa.oChipselect_n === 1'b0) begin
         if (ifa.oWrite_n === 1'b0) begin
            loga.push_back({2'd0, ifa.oAddress, ifa.odat});
            case (ifa.oAddress)
               4'd3: ka[79:48] <= ifa.odat;
               4'd2: ka[47:16] <= ifa.odat;
               4'd1: ka[15:0]  <= ifa.odat[15:0];
               4'd5: da[63:32] <= ifa.odat;
               4'd4: da[31:0]  <= ifa.odat;
               4'd8: ma        <= ifa.odat[0];
               4'd0: if (ifa.odat[0]) ra <= ma ? present_dec(da, ka) : present_enc(da, ka);
               default: ;
            endcase
         end else if (ifa.oRead_n === 1'b0) begin
            loga.push_back({2'd2, ifa.oAddress, 32'd0});
            ifa.idat <= (ifa.oAddress == 4'd7) ? ra[63:32] :
                        (ifa.oAddress == 4'd6) ? ra[31:0] : 32'd0;
         end else begin
            loga.push_back({2'd1, ifa.oAddress, ifa.odat});
         end
      end
   end

   always @(posedge clk) begin
      if (ifb.oChipselect_n === 1'b0) begin
         if (ifb.oWrite_n === 1'b0) begin
            case (ifb.oAddress)
               4'd3: kb[79:48] <= ifb.odat;
               4'd2: kb[47:16] <= ifb.odat;
               4'd1: kb[15:0]  <= ifb.odat[15:0];
               4'd5: db[63:32] <= ifb.odat;
               4'd4: db[31:0]  <= ifb.odat;
               4'd8: mb        <= ifb.odat[0];
               4'd0: if (ifb.odat[0]) rb <= mb ? present_dec(db, kb) : present_enc(db, kb);
               default: ;
            endcase
         end else if (ifb.oRead_n === 1'b0) begin
            ifb.idat <= (ifb.oAddress == 4'd7) ? rb[63:32] :
                        (ifb.oAddress == 4'd6) ? rb[31:0] : 32'd0;
         end
      end
   end

   // Bus rules that must hold on every cycle of both instances.
   always @(negedge clk) begin
      if (iReset_n === 1'b1) begin
         if (ifa.oWrite_n === 1'b0 && ifa.oRead_n === 1'b0) begin
            errors++;
            $display("FAIL strobe_overlap_a: write_n=0 and read_n=0 together, required never");
         end
         if (ifb.oWrite_n === 1'b0 && ifb.oRead_n === 1'b0) begin
            errors++;
            $display("FAIL strobe_overlap_b: write_n=0 and read_n=0 together, required never");
         end
         if (ifa.oWrite_n === 1'b1 && ifa.odat !== 32'd0) begin
            errors++;
            $display("FAIL odat_idle_a: odat=%h with write_n=1, required 0", ifa.odat);
         end
         if (ifb.oWrite_n === 1'b1 && ifb.odat !== 32'd0) begin
            errors++;
            $display("FAIL odat_idle_b: odat=%h with write_n=1, required 0", ifb.odat);
         end
      end
   end

   logic [63:0] sb[$];

   // One full transaction on instance s; hold = cycles rsp_ready stays low
   // after rsp_valid appears (with stray cmd_valid pulses meanwhile).
   task automatic run_txn(input logic s, input logic [79:0] key, input logic [63:0] data,
                          input logic mode, input int hold, output logic [63:0] got);
      int k;
      int exp_lat;
      logic [63:0] first;
      logic [63:0] exp;
      sel = s;
      exp_lat = 13 + (s ? 1 : 40);
      k = 0;
      while (cmd_ready_m !== 1'b1 && k < 100) begin @(posedge clk); #1; k++; end
      checks++;
      if (cmd_ready_m !== 1'b1) begin
         errors++;
         $display("FAIL cmd_ready_wait: cmd_ready=%b, required 1", cmd_ready_m);
      end
      cmd_key_d = key; cmd_data_d = data; cmd_mode_d = mode; cmd_valid_d = 1'b1;
      sb.push_back(mode ? present_dec(data, key) : present_enc(data, key));
      @(posedge clk); #1;
      // Command inputs are scrambled right after the handshake.
      cmd_valid_d = 1'b0; cmd_key_d = ~key; cmd_data_d = ~data; cmd_mode_d = ~mode;
      k = 1;
      while (rsp_valid_m !== 1'b1 && k < 400) begin @(posedge clk); #1; k++; end
      checks++;
      if (rsp_valid_m !== 1'b1 || k != exp_lat) begin
         errors++;
         $display("FAIL rsp_latency: rsp_valid=%b at cycle accept+%0d, required 1 at accept+%0d",
                  rsp_valid_m, k, exp_lat);
      end
      first = rsp_data_m;
      for (int i = 0; i < hold; i++) begin
         cmd_valid_d = (i % 3 == 1);
         @(posedge clk); #1;
         checks++;
         if (rsp_valid_m !== 1'b1 || rsp_data_m !== first || cmd_ready_m !== 1'b0) begin
            errors++;
            $display("FAIL rsp_hold: cyc %0d valid=%b data=%h cmd_ready=%b, required 1/%h/0",
                     i, rsp_valid_m, rsp_data_m, cmd_ready_m, first);
         end
      end
      cmd_valid_d = 1'b0;
      rsp_ready_d = 1'b1;
      got = rsp_data_m;
      @(posedge clk); #1;
      rsp_ready_d = 1'b0;
      checks++;
      if (rsp_valid_m !== 1'b0 || cmd_ready_m !== 1'b1 || busy_m !== 1'b0 || rsp_data_m !== got) begin
         errors++;
         $display("FAIL rsp_handshake: valid=%b cmd_ready=%b busy=%b data=%h, required 0/1/0/%h",
                  rsp_valid_m, cmd_ready_m, busy_m, rsp_data_m, got);
      end
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty: queue size 0, required 1");
      end else begin
         exp = sb.pop_front();
         if (got !== exp) begin
            errors++;
            $display("FAIL rsp_data: got %h, required %h", got, exp);
         end
      end
   endtask

   task automatic test_reset();
      iReset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({ifa.oChipselect_n, ifa.oWrite_n, ifa.oRead_n, ifa.oAddress, ifa.odat} !== {3'b111, 4'd0, 32'd0}) begin
         errors++;
         $display("FAIL reset_bus: cs/wr/rd=%b%b%b addr=%h odat=%h, required 111/0/0",
                  ifa.oChipselect_n, ifa.oWrite_n, ifa.oRead_n, ifa.oAddress, ifa.odat);
      end
      checks++;
      if ({ifa.rsp_valid, ifa.rsp_data, ifa.busy, ifa.cmd_ready} !== {1'b0, 64'd0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_ctrl: rsp_valid=%b rsp_data=%h busy=%b cmd_ready=%b, required 0/0/0/1",
                  ifa.rsp_valid, ifa.rsp_data, ifa.busy, ifa.cmd_ready);
      end
      iReset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_zero(output logic [63:0] r);
      loga.delete();
      run_txn(1'b0, 80'h0, 64'h0, 1'b0, 0, r);
      checks++;
      if (r !== 64'h5579C1387B228445) begin
         errors++;
         $display("FAIL zero_vector: got %h, required 5579c1387b228445", r);
      end
   endtask

   task automatic test_key_ones();
      logic [63:0] r;
      logic [1:0]  ek [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
      logic [3:0]  ea [8] = '{4'd3, 4'd2, 4'd1, 4'd5, 4'd4, 4'd8, 4'd0, 4'd0};
      logic [31:0] ed [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000FFFF, 32'h0,
                              32'h0, 32'h0, 32'h1, 32'h0};
      loga.delete();
      run_txn(1'b0, {80{1'b1}}, 64'h0, 1'b0, 0, r);
      checks++;
      if (r !== 64'hE72C46C0F5945049) begin
         errors++;
         $display("FAIL ones_vector: got %h, required e72c46c0f5945049", r);
      end
      checks++;
      if (loga.size() != 10) begin
         errors++;
         $display("FAIL trace_len: %0d bus cycles, required 10", loga.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (loga[i] !== {ek[i], ea[i], ed[i]}) begin
               errors++;
               $display("FAIL trace_%0d: kind=%0d addr=%h data=%h, required kind=%0d addr=%h data=%h",
                        i, loga[i].kind, loga[i].addr, loga[i].data, ek[i], ea[i], ed[i]);
            end
         end
         checks++;
         if (loga[8].kind !== 2'd2 || loga[8].addr !== 4'd7 || loga[9].kind !== 2'd2 || loga[9].addr !== 4'd6) begin
            errors++;
            $display("FAIL trace_reads: addr %h then %h, required reads of 7 then 6",
                     loga[8].addr, loga[9].addr);
         end
      end
   endtask

   task automatic test_round_trip(input logic [63:0] ct);
      logic [63:0] r;
      loga.delete();
      run_txn(1'b0, 80'h0, ct, 1'b1, 0, r);
      checks++;
      if (r !== 64'h0) begin
         errors++;
         $display("FAIL round_trip: got %h, required 0", r);
      end
      checks++;
      if (loga.size() < 6 || loga[5].addr !== 4'd8 || loga[5].data !== 32'h1) begin
         errors++;
         $display("FAIL ctrl_write: write data %h, required 00000001 at addr 8",
                  (loga.size() < 6) ? 32'hX : loga[5].data);
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] r;
      loga.delete();
      run_txn(1'b0, {16'($urandom), $urandom, $urandom}, {$urandom, $urandom}, 1'b0, 10, r);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (loga.size() != 10) begin
         errors++;
         $display("FAIL stray_cmd: %0d bus cycles, required 10", loga.size());
      end
   endtask

   task automatic test_reset_mid_wait();
      logic [63:0] r;
      int k;
      sel = 1'b0;
      k = 0;
      while (ifa.cmd_ready !== 1'b1 && k < 100) begin @(posedge clk); #1; k++; end
      loga.delete();
      cmd_key_d = 80'h0123_4567_89AB_CDEF_0011; cmd_data_d = 64'hDEAD_BEEF_CAFE_F00D;
      cmd_mode_d = 1'b0; cmd_valid_d = 1'b1;
      @(posedge clk); #1;
      cmd_valid_d = 1'b0;
      repeat (19) begin @(posedge clk); #1; end
      iReset_n = 1'b0;
      #1;
      checks++;
      if ({ifa.oChipselect_n, ifa.oWrite_n, ifa.oRead_n, ifa.busy, ifa.rsp_valid} !== 5'b11100) begin
         errors++;
         $display("FAIL reset_abort: cs/wr/rd/busy/rsp_valid=%b%b%b%b%b, required 11100",
                  ifa.oChipselect_n, ifa.oWrite_n, ifa.oRead_n, ifa.busy, ifa.rsp_valid);
      end
      repeat (2) @(posedge clk);
      #1;
      iReset_n = 1'b1;
      repeat (60) @(posedge clk);
      #1;
      checks++;
      if (loga.size() != 8 || ifa.rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_resume: %0d bus cycles rsp_valid=%b, required 8 and 0",
                  loga.size(), ifa.rsp_valid);
      end
      run_txn(1'b0, 80'hA5A5_5A5A_0F0F_F0F0_1234, 64'h0011_2233_4455_6677, 1'b0, 0, r);
   endtask

   task automatic test_w1();
      logic [63:0] r;
      run_txn(1'b1, {80{1'b1}}, 64'h0, 1'b0, 0, r);
      checks++;
      if (r !== 64'hE72C46C0F5945049) begin
         errors++;
         $display("FAIL w1_vector: got %h, required e72c46c0f5945049", r);
      end
      run_txn(1'b1, {16'($urandom), $urandom, $urandom}, {$urandom, $urandom}, 1'b1, 3, r);
      sel = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [63:0] r;
      for (int i = 0; i < 3; i++)
         run_txn(1'b0, {16'($urandom), $urandom, $urandom}, {$urandom, $urandom},
                 1'($urandom_range(0, 1)), 0, r);
   endtask

   initial begin
      logic [63:0] r1;
      iReset_n = 1'b0;
      test_reset();
      test_zero(r1);
      test_key_ones();
      test_round_trip(r1);
      test_backpressure();
      test_reset_mid_wait();
      test_w1();
      test_back_to_back();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_left: %0d entries, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation still running, required completion");
      $fatal(1, "timeout");
   end

endmodule
